// File: rtl/ex_pkg.sv
// ex_pkg: shared definitions for the execute issue stage.
//   - EX_XLEN / EX_RADDR_W : default datapath and register-address widths
//   - OP_*                 : ALU opcode encodings (anything else is a NOP)
//   - ex_entry_t           : one decoded op as stored in the issue buffer
package ex_pkg;

    localparam int EX_XLEN    = 32;
    localparam int EX_RADDR_W = 5;

    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SRL = 3'b110;

    // op2 already holds the immediate when use_imm is set; use_imm is kept
    // so held-op forwarding knows not to overwrite it.
    typedef struct packed {
        logic [2:0]            opcode;
        logic [EX_RADDR_W-1:0] rs1_addr;
        logic [EX_RADDR_W-1:0] rs2_addr;
        logic                  use_imm;
        logic [EX_XLEN-1:0]    op1;
        logic [EX_XLEN-1:0]    op2;
        logic [EX_RADDR_W-1:0] rd_addr;
    } ex_entry_t;

endpackage

// File: rtl/ex_fwd_sel.sv
// ex_fwd_sel: combinational writeback-forward select for one operand.
//   addr_i / data_i          : source register address and current value
//   fwd_valid_i / fwd_rd_addr_i / fwd_data_i : writeback completing this cycle
//   data_o                   : fwd_data_i on a nonzero address match, else data_i
// x0 is never forwarded, so a read of x0 keeps the register-file value.
module ex_fwd_sel #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input  logic [RADDR_W-1:0] addr_i,
    input  logic [XLEN-1:0]    data_i,
    input  logic               fwd_valid_i,
    input  logic [RADDR_W-1:0] fwd_rd_addr_i,
    input  logic [XLEN-1:0]    fwd_data_i,
    output logic [XLEN-1:0]    data_o
);

    assign data_o = (fwd_valid_i && (addr_i != '0) && (addr_i == fwd_rd_addr_i))
                    ? fwd_data_i : data_i;

endmodule

// File: rtl/ex_issue_stage.sv
// ex_issue_stage: decode-to-execute pipeline register feeding the ALU.
// Two-entry skid buffer (main + skid). Outputs come straight from the main
// entry flops; in_ready is a flop equal to !skid_valid.
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high (in_valid & in_ready on the input side, out_valid & out_ready on the
// output side); a valid op holds its fields stable until it transfers, apart
// from writeback-forwarding updates of its stored operands.
//
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   in_valid/in_ready + in_*      : decoded op from decode
//   flush                         : drop every held and incoming op
//   fwd_valid/fwd_rd_addr/fwd_data: writeback completing this cycle
//   out_valid/out_ready + alu_*, out_rd_addr : op presented to the ALU
//
// Build option: EX_SHAMT_MASK_EN masks alu_operand_2 to its low 5 bits for
// SLL/SRL on the output path.
module ex_issue_stage #(
    parameter int XLEN    = ex_pkg::EX_XLEN,
    parameter int RADDR_W = ex_pkg::EX_RADDR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         in_opcode,
    input  logic [RADDR_W-1:0] in_rs1_addr,
    input  logic [RADDR_W-1:0] in_rs2_addr,
    input  logic [XLEN-1:0]    in_rs1_data,
    input  logic [XLEN-1:0]    in_rs2_data,
    input  logic [XLEN-1:0]    in_imm,
    input  logic               in_use_imm,
    input  logic [RADDR_W-1:0] in_rd_addr,
    input  logic               flush,
    input  logic               fwd_valid,
    input  logic [RADDR_W-1:0] fwd_rd_addr,
    input  logic [XLEN-1:0]    fwd_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2:0]         alu_opcode,
    output logic [XLEN-1:0]    alu_operand_1,
    output logic [XLEN-1:0]    alu_operand_2,
    output logic [RADDR_W-1:0] out_rd_addr
);
    import ex_pkg::*;

    ex_entry_t main_q, main_d, skid_q, skid_d;
    ex_entry_t cap_e, main_fw, skid_fw;
    logic      main_valid_q, main_valid_d;
    logic      skid_valid_q, skid_valid_d;
    logic      in_ready_q, in_ready_d;
    logic      accept, drain;

    logic [XLEN-1:0] cap_op1, cap_op2;
    logic [XLEN-1:0] main_op1, main_op2, skid_op1, skid_op2;

    assign accept = in_valid && in_ready_q;
    assign drain  = main_valid_q && out_ready;

    // Forward selects: capture path, then each held entry.
    ex_fwd_sel #(.XLEN(XLEN), .RADDR_W(RADDR_W)) u_cap_rs1 (
        .addr_i(in_rs1_addr), .data_i(in_rs1_data), .fwd_valid_i(fwd_valid),
        .fwd_rd_addr_i(fwd_rd_addr), .fwd_data_i(fwd_data), .data_o(cap_op1));
    ex_fwd_sel #(.XLEN(XLEN), .RADDR_W(RADDR_W)) u_cap_rs2 (
        .addr_i(in_rs2_addr), .data_i(in_rs2_data), .fwd_valid_i(fwd_valid),
        .fwd_rd_addr_i(fwd_rd_addr), .fwd_data_i(fwd_data), .data_o(cap_op2));
    ex_fwd_sel #(.XLEN(XLEN), .RADDR_W(RADDR_W)) u_main_rs1 (
        .addr_i(main_q.rs1_addr), .data_i(main_q.op1), .fwd_valid_i(fwd_valid),
        .fwd_rd_addr_i(fwd_rd_addr), .fwd_data_i(fwd_data), .data_o(main_op1));
    ex_fwd_sel #(.XLEN(XLEN), .RADDR_W(RADDR_W)) u_main_rs2 (
        .addr_i(main_q.rs2_addr), .data_i(main_q.op2), .fwd_valid_i(fwd_valid),
        .fwd_rd_addr_i(fwd_rd_addr), .fwd_data_i(fwd_data), .data_o(main_op2));
    ex_fwd_sel #(.XLEN(XLEN), .RADDR_W(RADDR_W)) u_skid_rs1 (
        .addr_i(skid_q.rs1_addr), .data_i(skid_q.op1), .fwd_valid_i(fwd_valid),
        .fwd_rd_addr_i(fwd_rd_addr), .fwd_data_i(fwd_data), .data_o(skid_op1));
    ex_fwd_sel #(.XLEN(XLEN), .RADDR_W(RADDR_W)) u_skid_rs2 (
        .addr_i(skid_q.rs2_addr), .data_i(skid_q.op2), .fwd_valid_i(fwd_valid),
        .fwd_rd_addr_i(fwd_rd_addr), .fwd_data_i(fwd_data), .data_o(skid_op2));

    // Captured entry and forward-refreshed copies of the held entries.
    always_comb begin
        cap_e          = '0;
        cap_e.opcode   = in_opcode;
        cap_e.rs1_addr = in_rs1_addr;
        cap_e.rs2_addr = in_rs2_addr;
        cap_e.use_imm  = in_use_imm;
        cap_e.op1      = cap_op1;
        cap_e.op2      = in_use_imm ? in_imm : cap_op2;
        cap_e.rd_addr  = in_rd_addr;

        main_fw     = main_q;
        main_fw.op1 = main_op1;
        if (!main_q.use_imm) main_fw.op2 = main_op2;

        skid_fw     = skid_q;
        skid_fw.op1 = skid_op1;
        if (!skid_q.use_imm) skid_fw.op2 = skid_op2;
    end

    // Buffer control. Skid is only ever valid while main is valid.
    always_comb begin
        main_d       = main_fw;
        skid_d       = skid_fw;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;

        if (!main_valid_q) begin
            if (accept) begin
                main_d       = cap_e;
                main_valid_d = 1'b1;
            end
        end else if (drain) begin
            if (skid_valid_q) begin
                // in_ready is low here, so no input can be accepted.
                main_d       = skid_fw;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_d = cap_e;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = cap_e;
            skid_valid_d = 1'b1;
        end

        // Flush drops validity only; a same-cycle drain was still consumed.
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end

        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign out_valid     = main_valid_q;
    assign alu_opcode    = main_q.opcode;
    assign alu_operand_1 = main_q.op1;
    assign out_rd_addr   = main_q.rd_addr;

`ifdef EX_SHAMT_MASK_EN
    // RV32 shifts use only the low 5 bits of the shift amount.
    assign alu_operand_2 = ((main_q.opcode == OP_SLL) || (main_q.opcode == OP_SRL))
                           ? {{(XLEN-5){1'b0}}, main_q.op2[4:0]} : main_q.op2;
`else
    assign alu_operand_2 = main_q.op2;
`endif

endmodule

// File: tb/tb_ex_issue_stage.sv
module tb_ex_issue_stage;

  localparam int XLEN    = 32;
  localparam int RADDR_W = 5;
  localparam logic [2:0] T_SLL = 3'b101;
  localparam logic [2:0] T_SRL = 3'b110;
`ifdef EX_SHAMT_MASK_EN
  localparam bit MASK_EN = 1'b1;
`else
  localparam bit MASK_EN = 1'b0;
`endif

  // ---------------- clock / DUT ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, in_valid, in_ready, in_use_imm, flush, fwd_valid;
  logic [2:0]         in_opcode, alu_opcode;
  logic [RADDR_W-1:0] in_rs1_addr, in_rs2_addr, in_rd_addr, fwd_rd_addr, out_rd_addr;
  logic [XLEN-1:0]    in_rs1_data, in_rs2_data, in_imm, fwd_data;
  logic [XLEN-1:0]    alu_operand_1, alu_operand_2;
  logic               out_valid, out_ready;

  ex_issue_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_imm(in_imm), .in_use_imm(in_use_imm), .in_rd_addr(in_rd_addr),
    .flush(flush), .fwd_valid(fwd_valid), .fwd_rd_addr(fwd_rd_addr), .fwd_data(fwd_data),
    .out_valid(out_valid), .out_ready(out_ready), .alu_opcode(alu_opcode),
    .alu_operand_1(alu_operand_1), .alu_operand_2(alu_operand_2), .out_rd_addr(out_rd_addr)
  );

  // ---------------- vector table ----------------
  typedef struct {
    bit rst, iv, use_imm, flush, fv, ordy;
    logic [2:0] opc;
    logic [RADDR_W-1:0] rs1a, rs2a, rd, frd;
    logic [XLEN-1:0] rs1d, rs2d, imm, fd;
    bit e_rdy, e_vld, e_chk;
    logic [2:0] e_opc;
    logic [XLEN-1:0] e_op1, e_op2;
    logic [RADDR_W-1:0] e_rd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t vin(bit r, bit iv, logic [2:0] opc,
                               logic [RADDR_W-1:0] rs1a, logic [XLEN-1:0] rs1d,
                               logic [RADDR_W-1:0] rs2a, logic [XLEN-1:0] rs2d,
                               bit ui, logic [XLEN-1:0] imm, logic [RADDR_W-1:0] rd, bit ordy);
    vec_t v;
    v = '{default: '0};
    v.rst = r; v.iv = iv; v.opc = opc; v.rs1a = rs1a; v.rs1d = rs1d;
    v.rs2a = rs2a; v.rs2d = rs2d; v.use_imm = ui; v.imm = imm; v.rd = rd; v.ordy = ordy;
    return v;
  endfunction

  function automatic vec_t idle(bit ordy);
    return vin(0, 0, 3'd0, 5'd0, 32'd0, 5'd0, 32'd0, 0, 32'd0, 5'd0, ordy);
  endfunction

  function automatic vec_t wfwd(vec_t v, logic [RADDR_W-1:0] frd, logic [XLEN-1:0] fd);
    v.fv = 1'b1; v.frd = frd; v.fd = fd;
    return v;
  endfunction

  function automatic vec_t wflush(vec_t v);
    v.flush = 1'b1;
    return v;
  endfunction

  task automatic add(input vec_t v, input bit rdy, input bit vld, input bit chk,
                     input logic [2:0] opc, input logic [XLEN-1:0] op1,
                     input logic [XLEN-1:0] op2, input logic [RADDR_W-1:0] rd);
    v.e_rdy = rdy; v.e_vld = vld; v.e_chk = chk;
    v.e_opc = opc; v.e_op1 = op1; v.e_op2 = op2; v.e_rd = rd;
    vecs.push_back(v);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [2:0] opc;
    logic [RADDR_W-1:0] rs1, rs2, rd;
    bit use_imm;
    logic [XLEN-1:0] op1, op2;
  } m_op_t;

  m_op_t m_q[$];
  bit    m_ready;

  function automatic logic [XLEN-1:0] fwd_val(logic [RADDR_W-1:0] a, logic [XLEN-1:0] d);
    if (fwd_valid && a != 0 && a == fwd_rd_addr) return fwd_data;
    return d;
  endfunction

  function automatic logic [XLEN-1:0] exp_op2(m_op_t o);
    if (MASK_EN && (o.opc == T_SLL || o.opc == T_SRL)) return o.op2 & 32'h1f;
    return o.op2;
  endfunction

  // Queue of at most two ops; the head is what the ALU sees.
  task automatic model_update();
    bit acc, drn;
    m_op_t n;
    acc = in_valid && m_ready;
    drn = (m_q.size() > 0) && out_ready;
    foreach (m_q[i]) begin
      m_q[i].op1 = fwd_val(m_q[i].rs1, m_q[i].op1);
      if (!m_q[i].use_imm) m_q[i].op2 = fwd_val(m_q[i].rs2, m_q[i].op2);
    end
    if (drn) void'(m_q.pop_front());
    if (acc) begin
      n.opc = in_opcode; n.rs1 = in_rs1_addr; n.rs2 = in_rs2_addr; n.rd = in_rd_addr;
      n.use_imm = in_use_imm;
      n.op1 = fwd_val(in_rs1_addr, in_rs1_data);
      n.op2 = in_use_imm ? in_imm : fwd_val(in_rs2_addr, in_rs2_data);
      m_q.push_back(n);
    end
    if (flush || rst) m_q.delete();
    m_ready = (m_q.size() < 2);
  endtask

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input vec_t v);
    rst = v.rst; in_valid = v.iv; in_opcode = v.opc;
    in_rs1_addr = v.rs1a; in_rs2_addr = v.rs2a; in_rs1_data = v.rs1d; in_rs2_data = v.rs2d;
    in_imm = v.imm; in_use_imm = v.use_imm; in_rd_addr = v.rd;
    flush = v.flush; fwd_valid = v.fv; fwd_rd_addr = v.frd; fwd_data = v.fd;
    out_ready = v.ordy;
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  // ---------------- test ----------------
  initial begin
    vec_t v;
    logic [XLEN-1:0] sh_exp1, sh_exp2;
    m_ready = 1'b1;
    drive(idle(0));
    rst = 1'b1;

    sh_exp1 = MASK_EN ? 32'd1 : 32'd33;
    sh_exp2 = MASK_EN ? 32'd5 : 32'h25;

    // reset and single op
    add(vin(1, 0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0), 1, 0, 1, 3'b000, 0, 0, 0);
    add(vin(0, 1, 3'b001, 1, 5, 2, 7, 0, 0, 3, 1), 1, 1, 1, 3'b001, 5, 7, 3);
    add(idle(1), 1, 0, 0, 0, 0, 0, 0);
    // backpressure / skid
    add(vin(0, 1, 3'b010, 1, 9, 2, 4, 0, 0, 4, 0), 1, 1, 1, 3'b010, 9, 4, 4);
    add(vin(0, 1, 3'b100, 1, 1, 2, 2, 0, 0, 5, 0), 0, 1, 1, 3'b010, 9, 4, 4);
    add(vin(0, 1, 3'b011, 1, 77, 2, 88, 0, 0, 9, 0), 0, 1, 1, 3'b010, 9, 4, 4);
    add(idle(1), 1, 1, 1, 3'b100, 1, 2, 5);
    add(idle(1), 1, 0, 0, 0, 0, 0, 0);
    // capture forward
    add(wfwd(vin(0, 1, 3'b001, 6, 1, 0, 0, 0, 0, 1, 1), 6, 32'h1234), 1, 1, 1, 3'b001, 32'h1234, 0, 1);
    add(wfwd(vin(0, 1, 3'b001, 0, 1, 0, 0, 0, 0, 2, 1), 0, 32'h1234), 1, 1, 1, 3'b001, 1, 0, 2);
    add(idle(1), 1, 0, 0, 0, 0, 0, 0);
    // held forward vs immediate
    add(vin(0, 1, 3'b001, 1, 2, 8, 3, 1, 32'hFFFFFFF0, 6, 0), 1, 1, 1, 3'b001, 2, 32'hFFFFFFF0, 6);
    add(wfwd(idle(0), 8, 32'h55), 1, 1, 1, 3'b001, 2, 32'hFFFFFFF0, 6);
    add(idle(1), 1, 0, 0, 0, 0, 0, 0);
    add(vin(0, 1, 3'b001, 1, 2, 8, 3, 0, 32'hFFFFFFF0, 6, 0), 1, 1, 1, 3'b001, 2, 3, 6);
    add(wfwd(idle(0), 8, 32'h55), 1, 1, 1, 3'b001, 2, 32'h55, 6);
    add(vin(0, 1, 3'b011, 8, 9, 0, 7, 0, 0, 7, 0), 0, 1, 1, 3'b001, 2, 32'h55, 6);
    add(wfwd(idle(0), 8, 32'h66), 0, 1, 1, 3'b001, 2, 32'h66, 6);
    add(idle(1), 1, 1, 1, 3'b011, 32'h66, 7, 7);
    add(idle(1), 1, 0, 0, 0, 0, 0, 0);
    // flush with both entries full
    add(vin(0, 1, 3'b010, 1, 32'h11, 2, 32'h22, 0, 0, 2, 0), 1, 1, 1, 3'b010, 32'h11, 32'h22, 2);
    add(vin(0, 1, 3'b100, 1, 32'h33, 2, 32'h44, 0, 0, 3, 0), 0, 1, 1, 3'b010, 32'h11, 32'h22, 2);
    add(wflush(vin(0, 1, 3'b001, 1, 32'h99, 2, 32'h98, 0, 0, 4, 0)), 1, 0, 0, 0, 0, 0, 0);
    add(idle(1), 1, 0, 0, 0, 0, 0, 0);
    add(idle(1), 1, 0, 0, 0, 0, 0, 0);
    // flush while empty also drops the accepted input
    add(wflush(vin(0, 1, 3'b001, 1, 3, 2, 4, 0, 0, 4, 1)), 1, 0, 0, 0, 0, 0, 0);
    add(idle(1), 1, 0, 0, 0, 0, 0, 0);
    // shift amount
    add(vin(0, 1, 3'b101, 1, 1, 2, 33, 0, 0, 8, 1), 1, 1, 1, 3'b101, 1, sh_exp1, 8);
    add(vin(0, 1, 3'b110, 1, 32'h80, 2, 0, 1, 32'h25, 9, 1), 1, 1, 1, 3'b110, 32'h80, sh_exp2, 9);
    add(vin(0, 1, 3'b111, 1, 32'hAB, 2, 32'hCD, 0, 0, 10, 1), 1, 1, 1, 3'b111, 32'hAB, 32'hCD, 10);
    add(idle(1), 1, 0, 0, 0, 0, 0, 0);
    // reset mid-transfer, with an input offered on the reset cycle
    add(vin(0, 1, 3'b001, 1, 5, 2, 6, 0, 0, 11, 0), 1, 1, 1, 3'b001, 5, 6, 11);
    add(vin(0, 1, 3'b010, 1, 7, 2, 8, 0, 0, 12, 0), 0, 1, 1, 3'b001, 5, 6, 11);
    add(vin(1, 1, 3'b011, 1, 7, 2, 8, 0, 0, 13, 1), 1, 0, 1, 3'b000, 0, 0, 0);
    add(idle(1), 1, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      drive(v);
      step();
      chk($sformatf("vec%0d in_ready", i), {31'd0, in_ready}, {31'd0, v.e_rdy});
      chk($sformatf("vec%0d out_valid", i), {31'd0, out_valid}, {31'd0, v.e_vld});
      if (v.e_chk) begin
        chk($sformatf("vec%0d alu_opcode", i), {29'd0, alu_opcode}, {29'd0, v.e_opc});
        chk($sformatf("vec%0d alu_operand_1", i), alu_operand_1, v.e_op1);
        chk($sformatf("vec%0d alu_operand_2", i), alu_operand_2, v.e_op2);
        chk($sformatf("vec%0d out_rd_addr", i), {27'd0, out_rd_addr}, {27'd0, v.e_rd});
      end
    end

    // randomized traffic against the queue model
    for (int c = 0; c < 3000; c++) begin
      rst         = ($urandom_range(0, 99) == 0);
      flush       = ($urandom_range(0, 39) == 0);
      in_valid    = ($urandom_range(0, 3) != 0);
      in_opcode   = 3'($urandom_range(0, 7));
      in_rs1_addr = 5'($urandom_range(0, 3));
      in_rs2_addr = 5'($urandom_range(0, 3));
      in_rs1_data = $urandom;
      in_rs2_data = $urandom;
      in_imm      = $urandom;
      in_use_imm  = ($urandom_range(0, 1) == 1);
      in_rd_addr  = 5'($urandom_range(0, 31));
      fwd_valid   = ($urandom_range(0, 1) == 1);
      fwd_rd_addr = 5'($urandom_range(0, 3));
      fwd_data    = $urandom;
      out_ready   = ($urandom_range(0, 2) != 0);
      step();
      chk("rand in_ready", {31'd0, in_ready}, {31'd0, m_ready});
      chk("rand out_valid", {31'd0, out_valid}, {31'd0, (m_q.size() > 0)});
      if (m_q.size() > 0) begin
        chk("rand alu_opcode", {29'd0, alu_opcode}, {29'd0, m_q[0].opc});
        chk("rand alu_operand_1", alu_operand_1, m_q[0].op1);
        chk("rand alu_operand_2", alu_operand_2, exp_op2(m_q[0]));
        chk("rand out_rd_addr", {27'd0, out_rd_addr}, {27'd0, m_q[0].rd});
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
